// File: rtl/cic_interpolator.sv
// cic_interpolator: CIC interpolator of order 3..5, ratio R = 1..32.
// Combs run at the input strobe rate, integrators on every enabled edge.
module cic_interpolator #(
  parameter int EXTBITWIDTH    = 43,
  parameter int COEBITWIDTH    = 16,
  parameter int MIXBITWIDTH    = 22,
  parameter int FILTERBITWIDTH = 18
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      cic_indicator,
  input  logic [COEBITWIDTH-1:0]    cic_param,
  input  logic                      config_sync,
  input  logic [MIXBITWIDTH-1:0]    data_in,
  output logic                      data_req,
  output logic                      cic_flag,
  output logic [FILTERBITWIDTH-1:0] cic_result
);

  localparam int EW = EXTBITWIDTH;
  localparam int FW = FILTERBITWIDTH;
  localparam int MW = MIXBITWIDTH;
  localparam logic [5:0] SHMAX = 6'(EW - FW);

  typedef logic signed [EW-1:0] ext_t;

  logic [COEBITWIDTH-1:0] stage_q;
  logic [4:0]             order_q;
  logic [4:0]             factor_q;
  logic [4:0]             shift_q;
  logic [4:0]             phase_q;
  logic [4:0]             phase_d;

  ext_t x_q;
  ext_t x_d;
  ext_t u_q;
  ext_t u_d;
  ext_t c_q [1:5];
  ext_t c_d [1:5];
  ext_t d_q [1:5];
  ext_t d_d [1:5];
  ext_t i_q [1:5];
  ext_t i_d [1:5];
  ext_t cin [1:5];

  logic [FW-1:0] res_q;
  logic [FW-1:0] res_d;
  logic          flag_q;

  logic [2:0] n_eff;
  logic [4:0] sh_eff;
  ext_t       c_n;
  ext_t       i_n;
  ext_t       i_sh;
  logic       strobe;
  logic       unused_cfg;

  assign unused_cfg = ^stage_q[COEBITWIDTH-1:15];

  assign strobe     = en && (phase_q == 5'd0);
  assign data_req   = strobe;
  assign cic_flag   = flag_q;
  assign cic_result = res_q;

  always_comb begin
    n_eff = 3'd3;
    if (order_q >= 5'd3 && order_q <= 5'd5) begin
      n_eff = order_q[2:0];
    end
    sh_eff = shift_q;
    if ({1'b0, shift_q} > SHMAX) begin
      sh_eff = SHMAX[4:0];
    end
  end

  always_comb begin
    unique case (n_eff)
      3'd4: begin
        c_n = c_q[4];
        i_n = i_q[4];
      end
      3'd5: begin
        c_n = c_q[5];
        i_n = i_q[5];
      end
      default: begin
        c_n = c_q[3];
        i_n = i_q[3];
      end
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    if (en) begin
      phase_d = (phase_q >= factor_q) ? 5'd0 : phase_q + 5'd1;
    end
    if (config_sync) begin
      phase_d = 5'd0;
    end

    x_d   = x_q;
    u_d   = u_q;
    res_d = res_q;
    i_sh  = i_n >> sh_eff;

    cin[1] = x_q;
    for (int k = 2; k <= 5; k++) begin
      cin[k] = c_q[k-1];
    end
    for (int k = 1; k <= 5; k++) begin
      c_d[k] = c_q[k];
      d_d[k] = d_q[k];
      i_d[k] = i_q[k];
    end

    // all five combs shift so a later order change sees valid history
    if (strobe) begin
      x_d = {{(EW-MW){data_in[MW-1]}}, data_in};
      for (int k = 1; k <= 5; k++) begin
        d_d[k] = cin[k];
        c_d[k] = cin[k] - d_q[k];
      end
    end

    if (en) begin
      u_d    = strobe ? c_n : '0;
      i_d[1] = i_q[1] + u_q;
      for (int k = 2; k <= 5; k++) begin
        i_d[k] = i_q[k] + i_q[k-1];
      end
      res_d = i_sh[FW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_q  <= '0;
      order_q  <= 5'd3;
      factor_q <= 5'd31;
      shift_q  <= 5'd0;
      phase_q  <= 5'd0;
      x_q      <= '0;
      u_q      <= '0;
      res_q    <= '0;
      flag_q   <= 1'b0;
      for (int k = 1; k <= 5; k++) begin
        c_q[k] <= '0;
        d_q[k] <= '0;
        i_q[k] <= '0;
      end
    end else begin
      if (cic_indicator) begin
        stage_q <= cic_param;
      end
      if (config_sync) begin
        order_q  <= stage_q[4:0];
        factor_q <= stage_q[9:5];
        shift_q  <= stage_q[14:10];
      end
      phase_q <= phase_d;
      x_q     <= x_d;
      u_q     <= u_d;
      res_q   <= res_d;
      flag_q  <= en;
      for (int k = 1; k <= 5; k++) begin
        c_q[k] <= c_d[k];
        d_q[k] <= d_d[k];
        i_q[k] <= i_d[k];
      end
    end
  end

endmodule

// File: tb/tb_cic_interpolator.sv
// tb_cic_interpolator: random and directed stimulus against an arithmetic
// CIC reference; expected samples are queued and matched on cic_flag.
module tb_cic_interpolator;

  localparam int EW = 43;
  localparam int CW = 16;
  localparam int MW = 22;
  localparam int FW = 18;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          cic_indicator = 1'b0;
  logic          config_sync = 1'b0;
  logic [CW-1:0] cic_param = '0;
  logic [MW-1:0] data_in = '0;
  logic          data_req;
  logic          cic_flag;
  logic [FW-1:0] cic_result;

  cic_interpolator #(
    .EXTBITWIDTH(EW),
    .COEBITWIDTH(CW),
    .MIXBITWIDTH(MW),
    .FILTERBITWIDTH(FW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .cic_indicator(cic_indicator),
    .cic_param(cic_param),
    .config_sync(config_sync),
    .data_in(data_in),
    .data_req(data_req),
    .cic_flag(cic_flag),
    .cic_result(cic_result)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [FW-1:0] expq[$];
  logic [FW-1:0] last_exp;
  bit            have_last = 0;

  // reference model state, indexed by enabled edges
  int          m_n;
  int          m_r;
  int          m_sh;
  int          m_phase;
  int          m_t;
  logic [15:0] m_stage;
  longint      xs[$];
  longint      us[$];
  int          se[$];

  task automatic chk(input bit ok, input string nm,
                     input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic longint binom(input longint n, input int k);
    longint r;
    if (k < 0 || n < k) return 0;
    r = 1;
    for (int i = 1; i <= k; i++) r = r * (n - k + i) / i;
    return r;
  endfunction

  // y(t) = sum_j u_j * C(t - e_j - 2, N-1), low FW bits above the shift
  function automatic logic [FW-1:0] expected(input int t);
    longint      acc;
    logic [63:0] a;
    acc = 0;
    foreach (se[j]) acc += us[j] * binom(t - se[j] - 2, m_n - 1);
    a = acc;
    a = a >> m_sh;
    return a[FW-1:0];
  endfunction

  // u_j = N-th difference of the low-rate input, N+1 samples back
  task automatic strobe_in(input logic [MW-1:0] din);
    int     j;
    int     n0;
    longint u;
    j = xs.size();
    n0 = j - 1 - m_n;
    u = 0;
    for (int m = 0; m <= m_n; m++) begin
      if (n0 - m >= 0)
        u += ((m % 2) ? -1 : 1) * binom(m_n, m) * xs[n0-m];
    end
    xs.push_back(longint'(signed'(din)));
    us.push_back(u);
    se.push_back(m_t);
  endtask

  task automatic apply_cfg(input logic [15:0] p);
    int o;
    int s;
    o = int'(p[4:0]);
    s = int'(p[14:10]);
    m_n = (o >= 3 && o <= 5) ? o : 3;
    m_r = int'(p[9:5]) + 1;
    m_sh = (s > EW - FW) ? EW - FW : s;
    m_phase = 0;
  endtask

  task automatic cycle(input bit e, input logic [MW-1:0] din);
    bit req;
    en = e;
    data_in = din;
    @(negedge clk);
    req = e && (m_phase == 0);
    chk(data_req === req, "data_req", data_req, req);
    if (e) begin
      if (req) strobe_in(din);
      expq.push_back(expected(m_t));
      m_t++;
      m_phase = (m_phase >= m_r - 1) ? 0 : m_phase + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_cycle(input bit ind, input bit syn,
                           input logic [15:0] p);
    en = 1'b0;
    cic_indicator = ind;
    config_sync = syn;
    cic_param = p;
    @(posedge clk);
    #1;
    cic_indicator = 1'b0;
    config_sync = 1'b0;
    if (syn) apply_cfg(m_stage);
    if (ind) m_stage = p;
  endtask

  task automatic configure(input int o, input int f, input int s);
    logic [4:0] o5;
    logic [4:0] f5;
    logic [4:0] s5;
    o5 = 5'(o);
    f5 = 5'(f);
    s5 = 5'(s);
    cfg_cycle(1'b1, 1'b0, {1'b0, s5, f5, o5});
    cfg_cycle(1'b0, 1'b1, 16'h0);
  endtask

  // reset with en/config strobes active: reset must win
  task automatic do_reset();
    rst = 1'b0;
    en = 1'b1;
    config_sync = 1'b1;
    cic_indicator = 1'b1;
    cic_param = 16'($urandom);
    data_in = MW'($urandom);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk(expq.size() == 0, "pending_at_reset", expq.size(), 0);
    expq.delete();
    rst = 1'b1;
    en = 1'b0;
    config_sync = 1'b0;
    cic_indicator = 1'b0;
    m_n = 3;
    m_r = 32;
    m_sh = 0;
    m_phase = 0;
    m_t = 0;
    m_stage = '0;
    xs.delete();
    us.delete();
    se.delete();
    @(negedge clk);
    chk(cic_result == 0, "rst_result", cic_result, 0);
    chk(cic_flag == 1'b0, "rst_flag", cic_flag, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    logic [FW-1:0] e;
    forever begin
      @(negedge clk);
      if (cic_flag === 1'b1) begin
        if (expq.size() == 0) begin
          chk(1'b0, "unexpected_flag", cic_result, 0);
        end else begin
          e = expq.pop_front();
          chk(cic_result === e, "result", cic_result, e);
          last_exp = e;
          have_last = 1;
        end
      end else if (have_last) begin
        chk(cic_result === last_exp, "hold", cic_result, last_exp);
      end
      if (rst !== 1'b1) have_last = 0;
    end
  end

  initial begin : stim
    logic [15:0] pa;
    logic [15:0] pb;

    // default config: R=32, order 3
    do_reset();
    for (int i = 0; i < 100; i++)
      cycle((i % 40) < 35, MW'($urandom));

    // impulse latency, order 3, R=4
    do_reset();
    configure(3, 3, 0);
    cycle(1'b1, MW'(1));
    for (int k = 1; k <= 30; k++) begin
      cycle(1'b1, MW'(0));
      if (k == 19) chk(cic_result == 0, "lat_pre", cic_result, 0);
      if (k == 20) chk(cic_result == 1, "lat_hit", cic_result, 1);
    end

    // DC gain R^(N-1) = 16
    do_reset();
    configure(3, 3, 0);
    for (int i = 0; i < 200; i++) cycle(1'b1, MW'(1));
    chk(cic_result == 16, "dc_r4", cic_result, 16);

    // 1600 * 32^4 >> 24 = 100
    do_reset();
    configure(5, 31, 24);
    for (int i = 0; i < 700; i++) cycle(1'b1, MW'(1600));
    chk(cic_result == 100, "dc_r32", cic_result, 100);

    // staging is zero after reset: order 3, R=1, shift 0
    do_reset();
    cfg_cycle(1'b0, 1'b1, 16'h0);
    for (int i = 0; i < 60; i++)
      cycle($urandom_range(0, 5) != 0, MW'($urandom_range(0, 255)));

    // simultaneous load/apply takes the old staged word
    do_reset();
    pa = {1'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7))};
    pb = {1'b0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7))};
    cfg_cycle(1'b1, 1'b0, pa);
    cfg_cycle(1'b1, 1'b1, pb);
    for (int i = 0; i < 150; i++)
      cycle((i < 60 || i >= 67) && $urandom_range(0, 9) != 0,
            MW'($urandom));
    cfg_cycle(1'b0, 1'b1, 16'h0);
    for (int i = 0; i < 150; i++)
      cycle($urandom_range(0, 9) != 0, MW'($urandom));

    // fully random configurations
    for (int s = 0; s < 3; s++) begin
      do_reset();
      configure($urandom_range(0, 7), $urandom_range(0, 31),
                $urandom_range(0, 31));
      for (int i = 0; i < 250; i++)
        cycle($urandom_range(0, 6) != 0, MW'($urandom));
    end

    en = 1'b0;
    repeat (2) @(negedge clk);
    chk(expq.size() == 0, "drain", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
